tfe_link_driver: RTL

Host-side initiator for the TensorFlowE core pin protocol (Datos_in/Ena_write/clear/enable_accu/Ena_read -> Datos_out/Ena_out). It accepts a byte stream of jobs on a valid/ready slave port and buffers them in a FIFO. For each job it sequences clear, byte writes, accumulate and read on the core pins, then returns the core result byte on a valid/ready master port. It sits on the driving side of the core pins, either in a test harness or on an FPGA/companion die.

---
 rtl/tfe_link_driver.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tfe_link_driver.sv
// -----------------------------------------------------------------------------
// tfe_link_driver
//
// Host-side initiator for the TensorFlowE core pin protocol. Job bytes arrive
// on a valid/ready slave port and are buffered in a small FIFO (byte + last
// flag). For each job the block pulses clear once, streams the job bytes with
// Ena_write, holds enable_accu for ACCU_CYCLES cycles, then raises Ena_read
// until the core answers with Ena_out. The captured result byte is offered on
// a valid/ready master port and held until it is consumed.
//
// Optional build macro: TFE_TIMEOUT_EN
//   defined   - READ is guarded by a TIMEOUT_CYCLES watchdog; on expiry a
//               0x00 result is returned with err_timeout=1.
//   undefined - READ waits indefinitely; err_timeout stays 0.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   s_valid/s_data/s_last  job byte stream in; s_ready = FIFO not full
//   tfe_datos              core Datos_in
//   tfe_ena_write          core Ena_write
//   tfe_clear              core clear
//   tfe_enable_accu        core enable_accu
//   tfe_ena_read           core Ena_read
//   tfe_result/tfe_ena_out core Datos_out / Ena_out
//   m_valid/m_data/m_ready result byte out
//   busy                   sequencer not idle
//   err_timeout            current result produced by the watchdog
// -----------------------------------------------------------------------------
module tfe_link_driver #(
    parameter int FIFO_DEPTH     = 8,
    parameter int ACCU_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tfe_datos,
    output logic       tfe_ena_write,
    output logic       tfe_clear,
    output logic       tfe_enable_accu,
    output logic       tfe_ena_read,
    input  logic [7:0] tfe_result,
    input  logic       tfe_ena_out,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    output logic       busy,
    output logic       err_timeout
);

    localparam int AW  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ACW = (ACCU_CYCLES > 1) ? $clog2(ACCU_CYCLES) : 1;

    // Parameter sanity checks at elaboration.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (ACCU_CYCLES < 1) begin : g_bad_accu
        $error("ACCU_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WRITE = 3'd2,
        ST_ACCU  = 3'd3,
        ST_READ  = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [8:0]  mem_r [FIFO_DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        full_s;
    logic        empty_s;
    logic        push_s;
    logic        pop_s;
    logic [8:0]  rd_data_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign s_ready   = !full_s;
    // Full refuses a push even when a pop frees a slot in the same cycle.
    assign push_s    = s_valid && !full_s;
    assign rd_data_s = mem_r[rd_ptr_r[AW-1:0]];

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 9'h000;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= {s_last, s_data};
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // ----------------------------------------------------------- sequencer
    state_t     state_r, state_n;
    logic [7:0] datos_r, datos_n;
    logic       ena_write_r, ena_write_n;
    logic       clear_r, clear_n;
    logic       accu_r, accu_n;
    logic       ena_read_r, ena_read_n;
    logic       m_valid_r, m_valid_n;
    logic [7:0] m_data_r, m_data_n;
    logic       busy_r, busy_n;
    logic       err_r, err_n;
    // Set while the byte currently on the pins carries the job's last flag.
    logic       wr_last_r, wr_last_n;
    logic [ACW-1:0] accu_cnt_r, accu_cnt_n;
`ifdef TFE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_r, tmo_cnt_n;
`endif

    // Sequencer state and registered pin/port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            datos_r     <= 8'h00;
            ena_write_r <= 1'b0;
            clear_r     <= 1'b0;
            accu_r      <= 1'b0;
            ena_read_r  <= 1'b0;
            m_valid_r   <= 1'b0;
            m_data_r    <= 8'h00;
            busy_r      <= 1'b0;
            err_r       <= 1'b0;
            wr_last_r   <= 1'b0;
            accu_cnt_r  <= '0;
`ifdef TFE_TIMEOUT_EN
            tmo_cnt_r   <= '0;
`endif
        end else begin
            state_r     <= state_n;
            datos_r     <= datos_n;
            ena_write_r <= ena_write_n;
            clear_r     <= clear_n;
            accu_r      <= accu_n;
            ena_read_r  <= ena_read_n;
            m_valid_r   <= m_valid_n;
            m_data_r    <= m_data_n;
            busy_r      <= busy_n;
            err_r       <= err_n;
            wr_last_r   <= wr_last_n;
            accu_cnt_r  <= accu_cnt_n;
`ifdef TFE_TIMEOUT_EN
            tmo_cnt_r   <= tmo_cnt_n;
`endif
        end
    end

    // Next-state and next-output decode. Outputs are computed one cycle
    // ahead, so the byte shown in a write cycle was popped the cycle before.
    always_comb begin
        state_n     = state_r;
        datos_n     = datos_r;
        ena_write_n = 1'b0;
        clear_n     = 1'b0;
        accu_n      = 1'b0;
        ena_read_n  = 1'b0;
        m_valid_n   = m_valid_r;
        m_data_n    = m_data_r;
        err_n       = err_r;
        wr_last_n   = 1'b0;
        accu_cnt_n  = accu_cnt_r;
        pop_s       = 1'b0;
`ifdef TFE_TIMEOUT_EN
        tmo_cnt_n   = tmo_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_n = ST_CLEAR;
                    clear_n = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CLEAR, ST_WRITE: begin
                if (state_r == ST_WRITE && wr_last_r) begin
                    state_n    = ST_ACCU;
                    accu_n     = 1'b1;
                    accu_cnt_n = '0;
                end else begin
                    state_n = ST_WRITE;
                    // Empty FIFO gives a bubble: ena_write low, datos held.
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        ena_write_n = 1'b1;
                        datos_n     = rd_data_s[7:0];
                        wr_last_n   = rd_data_s[8];
                    end else begin
                        ena_write_n = 1'b0;
                    end
                end
            end
            ST_ACCU: begin
                if (accu_cnt_r == ACW'(ACCU_CYCLES - 1)) begin
                    state_n    = ST_READ;
                    ena_read_n = 1'b1;
`ifdef TFE_TIMEOUT_EN
                    tmo_cnt_n  = '0;
`endif
                end else begin
                    accu_n     = 1'b1;
                    accu_cnt_n = accu_cnt_r + ACW'(1);
                end
            end
            ST_READ: begin
                if (tfe_ena_out) begin
                    state_n   = ST_HOLD;
                    m_valid_n = 1'b1;
                    m_data_n  = tfe_result;
                end else begin
`ifdef TFE_TIMEOUT_EN
                    if (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_n   = ST_HOLD;
                        m_valid_n = 1'b1;
                        m_data_n  = 8'h00;
                        err_n     = 1'b1;
                    end else begin
                        tmo_cnt_n  = tmo_cnt_r + TW'(1);
                        ena_read_n = 1'b1;
                    end
`else
                    ena_read_n = 1'b1;
`endif
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    state_n   = ST_IDLE;
                    m_valid_n = 1'b0;
                    err_n     = 1'b0;
                end else begin
                    state_n = ST_HOLD;
                end
            end
            default: begin
                state_n   = ST_IDLE;
                m_valid_n = 1'b0;
                err_n     = 1'b0;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    assign tfe_datos       = datos_r;
    assign tfe_ena_write   = ena_write_r;
    assign tfe_clear       = clear_r;
    assign tfe_enable_accu = accu_r;
    assign tfe_ena_read    = ena_read_r;
    assign m_valid         = m_valid_r;
    assign m_data          = m_data_r;
    assign busy            = busy_r;
    assign err_timeout     = err_r;

endmodule
